i2c_cmd_engine: RTL and testbench

//  I2C master byte-register transaction engine. Executes one command per IO_CONTROL_PULSE

---
 rtl/i2c_cmd_engine.sv | 163 ++++++++++++++++
 tb/tb_i2c_cmd_engine.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_engine.sv
// i2c_cmd_engine: I2C master running one register write or read per command strobe.
// Optional slave clock stretching is enabled by defining I2C_CLK_STRETCH_EN.
module i2c_cmd_engine #(
    parameter logic [15:0] CLK_DIV = 16'd250
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       IO_CONTROL_PULSE,
    input  logic       IO_CONTROL_RW,
    input  logic [7:0] IO_CONTROL_ID,
    input  logic [7:0] IO_ADDR_ADDR,
    input  logic [7:0] IO_WDATA_WDATA,
    output logic [7:0] IO_RDATA_RDATA,
    output logic       IO_CONTROL_CMPLT,
    output logic       ack_err,
    output logic       busy,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_t,
    output logic       sda_t
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_TX_ID, S_TX_ADDR, S_TX_WDATA,
        S_RSTART, S_TX_RID, S_RX, S_STOP, S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic [1:0]  phase;
    logic [3:0]  bit_cnt;
    logic [7:0]  tx_sh, rx_sh;
    logic [6:0]  id_q;
    logic [7:0]  addr_q, wdata_q;
    logic        rw_q, ack_bit;
    logic        hold, in_tx, in_byte, sample, phase_end, slot_end, byte_end;
    logic        unused_inputs;

`ifdef I2C_CLK_STRETCH_EN
    // The quarter-period count freezes at the start of the SCL-high phase until the pad reads high.
    assign hold          = (phase == 2'd2) && (cnt == CLK_DIV - 16'd1) && !scl_i;
    assign unused_inputs = IO_CONTROL_ID[7];
`else
    assign hold          = 1'b0;
    assign unused_inputs = ^{IO_CONTROL_ID[7], scl_i};
`endif

    assign in_tx     = (state == S_TX_ID) || (state == S_TX_ADDR) ||
                       (state == S_TX_WDATA) || (state == S_TX_RID);
    assign in_byte   = in_tx || (state == S_RX);
    assign sample    = in_byte && (phase == 2'd2) && (cnt == '0);
    assign phase_end = (cnt == '0) && !hold;
    assign slot_end  = phase_end && (phase == 2'd3);
    assign byte_end  = slot_end && in_byte && (bit_cnt == 4'd8);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        scl_t     = 1'b1;
        sda_t     = 1'b1;
        case (state)
            S_IDLE: if (IO_CONTROL_PULSE) state_nxt = S_START;
            S_START, S_RSTART: begin
                scl_t = (phase != 2'd0);
                sda_t = !phase[1];
                if (slot_end) state_nxt = (state == S_START) ? S_TX_ID : S_TX_RID;
            end
            S_TX_ID, S_TX_ADDR, S_TX_WDATA, S_TX_RID: begin
                scl_t = phase[1];
                sda_t = (bit_cnt == 4'd8) || tx_sh[7];
                if (byte_end) begin
                    if (ack_bit || state == S_TX_WDATA) state_nxt = S_STOP;
                    else if (state == S_TX_ID)          state_nxt = S_TX_ADDR;
                    else if (state == S_TX_ADDR)        state_nxt = rw_q ? S_RSTART : S_TX_WDATA;
                    else                                state_nxt = S_RX;
                end
            end
            S_RX: begin
                scl_t = phase[1];
                if (byte_end) state_nxt = S_STOP;
            end
            S_STOP: begin
                scl_t = (phase != 2'd0);
                sda_t = (phase == 2'd3);
                if (slot_end) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt              <= CLK_DIV - 16'd1;
            phase            <= '0;
            bit_cnt          <= '0;
            tx_sh            <= '0;
            rx_sh            <= '0;
            id_q             <= '0;
            addr_q           <= '0;
            wdata_q          <= '0;
            rw_q             <= 1'b0;
            ack_bit          <= 1'b0;
            ack_err          <= 1'b0;
            IO_CONTROL_CMPLT <= 1'b0;
            IO_RDATA_RDATA   <= '0;
        end else begin
            IO_CONTROL_CMPLT <= 1'b0;
            if (state == S_IDLE) begin
                cnt     <= CLK_DIV - 16'd1;
                phase   <= '0;
                bit_cnt <= '0;
                if (IO_CONTROL_PULSE) begin
                    rw_q    <= IO_CONTROL_RW;
                    id_q    <= IO_CONTROL_ID[6:0];
                    addr_q  <= IO_ADDR_ADDR;
                    wdata_q <= IO_WDATA_WDATA;
                    ack_err <= 1'b0;
                end
            end else begin
                if (phase_end) begin
                    cnt   <= CLK_DIV - 16'd1;
                    phase <= phase + 2'd1;
                end else if (!hold) begin
                    cnt <= cnt - 16'd1;
                end
                if (slot_end && in_byte) begin
                    if (bit_cnt == 4'd8) begin
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                        tx_sh   <= {tx_sh[6:0], 1'b0};
                    end
                end
                if (sample) begin
                    if (bit_cnt == 4'd8)    ack_bit <= sda_i;
                    else if (state == S_RX) rx_sh   <= {rx_sh[6:0], sda_i};
                end
                if (byte_end && in_tx && ack_bit) ack_err <= 1'b1;
                // ack_err doubles as the abort flag: an aborted read returns all ones.
                if (state == S_DONE) begin
                    IO_CONTROL_CMPLT <= 1'b1;
                    if (rw_q) IO_RDATA_RDATA <= ack_err ? 8'hFF : rx_sh;
                end
            end
            if (state_nxt != state) begin
                case (state_nxt)
                    S_TX_ID:    tx_sh <= {id_q, 1'b0};
                    S_TX_ADDR:  tx_sh <= addr_q;
                    S_TX_WDATA: tx_sh <= wdata_q;
                    S_TX_RID:   tx_sh <= {id_q, 1'b1};
                    default:    ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_cmd_engine.sv
// Scoreboard bench for i2c_cmd_engine: behavioural I2C slave, bus-event and completion checks.
module tb_i2c_cmd_engine;

    localparam int CLK_DIV = 4;
    localparam int LAT_WR  = 29 * 4 * CLK_DIV + 1;
    localparam int LAT_RD  = 39 * 4 * CLK_DIV + 1;
    localparam int LAT_NAK = 11 * 4 * CLK_DIV + 1;
    localparam int EV_S    = 1000;
    localparam int EV_P    = 1001;
    localparam logic [6:0] SLV_ADDR = 7'h50;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       pulse = 1'b0, rw = 1'b0;
    logic [7:0] id = '0, addr = '0, wd = '0;
    logic [7:0] rdata;
    logic       cmplt, ack_err, busy, scl_t, sda_t;
    logic       scl_b, sda_b;
    logic       scl_drv = 1'b1, sda_drv = 1'b1;

    assign scl_b = scl_t & scl_drv;
    assign sda_b = sda_t & sda_drv;

    i2c_cmd_engine #(.CLK_DIV(16'(CLK_DIV))) dut (
        .clk(clk), .rstn(rstn),
        .IO_CONTROL_PULSE(pulse), .IO_CONTROL_RW(rw), .IO_CONTROL_ID(id),
        .IO_ADDR_ADDR(addr), .IO_WDATA_WDATA(wd), .IO_RDATA_RDATA(rdata),
        .IO_CONTROL_CMPLT(cmplt), .ack_err(ack_err), .busy(busy),
        .scl_i(scl_b), .sda_i(sda_b), .scl_t(scl_t), .sda_t(sda_t)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [7:0] rdata; logic ack; int cyc; } cmp_t;
    cmp_t cq[$];
    int   eq[$];
    int   checks = 0, errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic void bus_event(input int ev);
        int e;
        checks++;
        if (eq.size() == 0) begin
            errors++;
            $display("FAIL bus_event_unexpected actual=%0h expected=none", ev);
        end else begin
            e = eq.pop_front();
            if (ev != e) begin
                errors++;
                $display("FAIL bus_event actual=%0h expected=%0h", ev, e);
            end
        end
    endfunction

    // completion monitor
    initial begin
        cmp_t e;
        forever begin
            @(negedge clk);
            if (cmplt) begin
                if (cq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cmplt_unexpected actual=1 expected=0 at cycle %0d", cyc);
                end else begin
                    e = cq.pop_front();
                    chk("cmplt_cycle", cyc, e.cyc);
                    chk("cmplt_rdata", rdata, e.rdata);
                    chk("cmplt_ack_err", ack_err, e.ack);
                end
            end
        end
    end

    // behavioural slave at SLV_ADDR; reports START/STOP and {ack,byte} events
    logic [7:0] sh = '0, txd = 8'h3C;
    logic       pscl = 1'b1, psda = 1'b1, sending = 1'b0, addressed = 1'b0, ackv = 1'b1;
    logic       stretch_req = 1'b0;
    int         bitn = 0, byten = 0, hold_cnt = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                bitn = 0; byten = 0; sending = 1'b0; addressed = 1'b0; sda_drv = 1'b1;
            end else begin
                if (hold_cnt > 0) begin
                    hold_cnt--;
                    if (hold_cnt == 0) scl_drv = 1'b1;
                end
                if (scl_b && pscl && psda && !sda_b) begin
                    bus_event(EV_S);
                    bitn = 0; byten = 0; sending = 1'b0;
                end else if (scl_b && pscl && !psda && sda_b) begin
                    bus_event(EV_P);
                    bitn = 0; byten = 0; sending = 1'b0; addressed = 1'b0; sda_drv = 1'b1;
                end else if (scl_b && !pscl) begin
                    if (bitn < 8) begin
                        sh = {sh[6:0], sda_b};
                        bitn++;
                    end else if (bitn == 8) begin
                        ackv = sda_b;
                        bus_event({23'd0, ackv, sh});
                        bitn = 9;
                    end
                end else if (!scl_b && pscl) begin
                    if (bitn == 8) begin
                        if (sending) sda_drv = 1'b1;
                        else begin
                            if (byten == 0) addressed = (sh[7:1] == SLV_ADDR);
                            if (addressed) sda_drv = 1'b0;
                            if (stretch_req && byten == 0) begin
                                stretch_req = 1'b0;
                                scl_drv = 1'b0;
                                hold_cnt = 2 * CLK_DIV + 100;
                            end
                        end
                    end else if (bitn == 9) begin
                        sda_drv = 1'b1;
                        bitn = 0;
                        if (byten == 0 && addressed && sh[0] && !ackv) begin
                            sending = 1'b1;
                            sda_drv = txd[7];
                        end else if (sending) sending = 1'b0;
                        byten++;
                    end else if (sending && bitn >= 1 && bitn <= 7) begin
                        sda_drv = txd[7 - bitn];
                    end
                end
            end
            pscl = scl_b;
            psda = sda_b;
        end
    end

    task automatic issue(input logic r, input logic [7:0] i, input logic [7:0] a,
                         input logic [7:0] w, output int c0);
        @(negedge clk);
        pulse = 1'b1; rw = r; id = i; addr = a; wd = w;
        @(posedge clk);
        #1;
        c0 = cyc;
        pulse = 1'b0;
    endtask

    task automatic exp_cmp(input logic [7:0] rd, input logic ack, input int c);
        cmp_t e;
        e.rdata = rd; e.ack = ack; e.cyc = c;
        cq.push_back(e);
    endtask

    task automatic exp_write(input logic [7:0] i, input logic [7:0] a, input logic [7:0] w);
        eq.push_back(EV_S);
        eq.push_back(int'({i[6:0], 1'b0}));
        eq.push_back(int'(a));
        eq.push_back(int'(w));
        eq.push_back(EV_P);
    endtask

    task automatic wait_idle(input string nm, input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < limit);
        if (busy) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual=busy expected=idle within %0d cycles", nm, limit);
        end
    endtask

    initial begin
        int c0, dummy;
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, dummy;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_scl_t", scl_t, 1);
        chk("rst_sda_t", sda_t, 1);
        chk("rst_busy", busy, 0);
        chk("rst_cmplt", cmplt, 0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_ack_err", ack_err, 0);
        rstn = 1'b1;

        // register write, all ACKed
        exp_write(8'h50, 8'h10, 8'hA5);
        issue(1'b0, 8'h50, 8'h10, 8'hA5, c0);
        exp_cmp(8'h00, 1'b0, c0 + LAT_WR);
        chk("busy_after_accept", busy, 1);
        wait_idle("write", 1000);

        // register read returning 0x3C, master NACKs the data byte
        txd = 8'h3C;
        eq.push_back(EV_S); eq.push_back(32'h0A0); eq.push_back(32'h022);
        eq.push_back(EV_S); eq.push_back(32'h0A1); eq.push_back(32'h13C); eq.push_back(EV_P);
        issue(1'b1, 8'h50, 8'h22, 8'h00, c0);
        exp_cmp(8'h3C, 1'b0, c0 + LAT_RD);
        wait_idle("read", 1000);

        // write to an absent device: NACK on address byte, RDATA held
        eq.push_back(EV_S); eq.push_back(32'h1A2); eq.push_back(EV_P);
        issue(1'b0, 8'h51, 8'h10, 8'h11, c0);
        exp_cmp(8'h3C, 1'b1, c0 + LAT_NAK);
        wait_idle("nack_write", 1000);

        // read from an absent device returns all ones
        eq.push_back(EV_S); eq.push_back(32'h1A2); eq.push_back(EV_P);
        issue(1'b1, 8'h51, 8'h22, 8'h00, c0);
        exp_cmp(8'hFF, 1'b1, c0 + LAT_NAK);
        wait_idle("nack_read", 1000);

        // second strobe while busy must be ignored
        exp_write(8'h50, 8'h20, 8'h5A);
        issue(1'b0, 8'h50, 8'h20, 8'h5A, c0);
        exp_cmp(8'hFF, 1'b0, c0 + LAT_WR);
        repeat (9) @(posedge clk);
        issue(1'b1, 8'h50, 8'h77, 8'h00, dummy);
        chk("busy_during_ignored_pulse", busy, 1);
        wait_idle("ignored_pulse", 1000);

        // reset in the middle of the data byte
        eq.push_back(EV_S); eq.push_back(32'h0A0); eq.push_back(32'h030);
        issue(1'b0, 8'h50, 8'h30, 8'hC3, c0);
        repeat (340) @(posedge clk);
        @(negedge clk);
        chk("busy_before_reset", busy, 1);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_scl_t", scl_t, 1);
        chk("midrst_sda_t", sda_t, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_cmplt", cmplt, 0);
        chk("midrst_rdata", rdata, 8'h00);
        @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(posedge clk);

        // recovery write; ID bit 7 is ignored
        exp_write(8'h50, 8'h31, 8'h7E);
        issue(1'b0, 8'hD0, 8'h31, 8'h7E, c0);
        exp_cmp(8'h00, 1'b0, c0 + LAT_WR);
        wait_idle("recovery_write", 1000);

`ifdef I2C_CLK_STRETCH_EN
        // slave stretches SCL for 100 clocks in the first ACK slot
        stretch_req = 1'b1;
        exp_write(8'h50, 8'h44, 8'h99);
        issue(1'b0, 8'h50, 8'h44, 8'h99, c0);
        exp_cmp(8'h00, 1'b0, c0 + LAT_WR + 100);
        wait_idle("stretch_write", 2000);
`endif

        repeat (10) @(negedge clk);
        chk("pending_cmplt", cq.size(), 0);
        chk("pending_bus_events", eq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
